// File: rtl/fifo_uart_pkg.sv
// Shared constants and state encoding for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned IDX_W           = 3;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned FRAME_BITS_BASE = 10;
    localparam int unsigned FRAME_BITS_PAR  = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and pulses o_bit_done on the last one.
module baud_tick
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk_w,
    input  logic reset,
    input  logic i_restart,
    output logic o_bit_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    // Done is registered one cycle early so it coincides with the last count.
    always_ff @(posedge clk_w or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_restart) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
            r_done <= (r_cnt == PRE_CNT);
        end
    end

    assign o_bit_done = r_done;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them 8N1.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk_w,
    input  logic              reset,
    input  logic              fifo_empty,
    output logic              fifo_rde,
    input  logic [DATA_W-1:0] fifo_rdd,
    output logic              tx,
    output logic              busy
);

    tx_state_t         r_state;
    logic              r_tx;
    logic              r_rde;
    logic              r_busy;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic w_restart;
    logic w_bit_done;

    // Bit timer is held at zero outside the serial bit states.
    assign w_restart = (r_state == S_IDLE) || (r_state == S_POP) || (r_state == S_LOAD);

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_w      (clk_w),
        .reset      (reset),
        .i_restart  (w_restart),
        .o_bit_done (w_bit_done)
    );

    // Outputs are loaded with the value belonging to the state being entered.
    always_ff @(posedge clk_w or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_rde    <= 1'b0;
            r_busy   <= 1'b0;
            r_shift  <= '0;
            r_idx    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_rde <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        r_state <= S_POP;
                        r_rde   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift  <= fifo_rdd;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity <= ^fifo_rdd;
`endif
                    r_state  <= S_START;
                    r_tx     <= 1'b0;
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (!fifo_empty) begin
                            r_state <= S_POP;
                            r_rde   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rde = r_rde;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame scoreboard, per-scenario tasks.
module tb_fifo_uart_tx;

    localparam int unsigned CLKS = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned BUSY_EXP = CLKS * NB + 2;

    logic       clk_w = 1'b0;
    logic       reset = 1'b0;
    logic       fifo_empty;
    logic       fifo_rde;
    logic [7:0] fifo_rdd = 8'h00;
    logic       tx;
    logic       busy;

    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] exp_q [$];

    int cyc = 0;
    int rde_pulses = 0;
    int busy_cycles = 0;
    int tx_low_cycles = 0;
    int last_rde_cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .clk_w      (clk_w),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rde   (fifo_rde),
        .fifo_rdd   (fifo_rdd),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk_w = ~clk_w;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read side: data appears the cycle after the read enable.
    always @(posedge clk_w) begin
        cyc <= cyc + 1;
        if (fifo_rde) begin
            fifo_rdd <= mem[rd_ptr % 16];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always @(negedge clk_w) begin
        if (fifo_rde === 1'b1) begin
            rde_pulses   = rde_pulses + 1;
            last_rde_cyc = cyc;
        end
        if (busy === 1'b1) busy_cycles = busy_cycles + 1;
        if (tx !== 1'b1) tx_low_cycles = tx_low_cycles + 1;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef FIFO_UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Collects one frame starting from the next falling edge of tx; no checking here.
    task automatic rx_frame(output logic [10:0] bits, output logic stable,
                            output int waited, output logic tmo, output int start_cyc);
        bits = '1; stable = 1'b1; waited = 0; tmo = 1'b0; start_cyc = 0;
        forever begin
            @(negedge clk_w);
            if (tx === 1'b0) break;
            waited++;
            if (waited > 300) begin
                tmo = 1'b1;
                return;
            end
        end
        start_cyc = cyc;
        for (int b = 0; b < int'(NB); b++) begin
            for (int c = 0; c < int'(CLKS); c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk_w);
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(output logic tmo);
        tmo = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_w);
            if (busy === 1'b0) return;
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset;
        logic [10:0] bits; logic stable; int waited; logic tmo; int sc;
        logic [7:0] e;
        @(negedge clk_w);
        push_byte(8'h5A);
        repeat (3) @(negedge clk_w);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got=%b want=1", tx); end
        n_cmp++; if (fifo_rde !== 1'b0) begin n_err++; $display("FAIL reset_rde got=%b want=0", fifo_rde); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (rd_ptr !== 0) begin n_err++; $display("FAIL reset_no_pop rd_ptr=%0d want=0", rd_ptr); end
        reset = 1'b1;
        #1;
        n_cmp++; if (fifo_rde !== 1'b0) begin n_err++; $display("FAIL release_rde got=%b want=0", fifo_rde); end
        rx_frame(bits, stable, waited, tmo, sc);
        e = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL post_reset_timeout got=%b want=0", tmo); end
        n_cmp++; if (bits !== make_frame(e)) begin n_err++; $display("FAIL post_reset_frame got=%h want=%h", bits, make_frame(e)); end
        wait_idle(tmo);
    endtask

    task automatic test_single;
        logic [10:0] bits; logic stable; int waited; logic tmo; int sc;
        int r0, b0; logic [7:0] e;
        r0 = rde_pulses; b0 = busy_cycles;
        push_byte(8'hA5);
        rx_frame(bits, stable, waited, tmo, sc);
        e = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL single_timeout got=%b want=0", tmo); end
        n_cmp++; if (bits !== make_frame(e)) begin n_err++; $display("FAIL single_frame got=%h want=%h", bits, make_frame(e)); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL single_bit_hold got=%b want=1", stable); end
        n_cmp++; if (sc - last_rde_cyc !== 2) begin n_err++; $display("FAIL single_latency got=%0d want=2", sc - last_rde_cyc); end
        wait_idle(tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL single_idle_timeout got=%b want=0", tmo); end
        n_cmp++; if (rde_pulses - r0 !== 1) begin n_err++; $display("FAIL single_rde_count got=%0d want=1", rde_pulses - r0); end
        n_cmp++; if (busy_cycles - b0 !== int'(BUSY_EXP)) begin n_err++; $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles - b0, BUSY_EXP); end
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_idle_tx got=%b want=1", tx); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits; logic stable; int waited; logic tmo; int sc;
        int r0; logic [7:0] e;
        r0 = rde_pulses;
        push_byte(8'hA5);
        push_byte(8'hAA);
        for (int f = 0; f < 2; f++) begin
            rx_frame(bits, stable, waited, tmo, sc);
            e = exp_q.pop_front();
            n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL b2b_timeout[%0d] got=%b want=0", f, tmo); end
            n_cmp++; if (bits !== make_frame(e)) begin n_err++; $display("FAIL b2b_frame[%0d] got=%h want=%h", f, bits, make_frame(e)); end
            n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL b2b_hold[%0d] got=%b want=1", f, stable); end
            if (f == 1) begin
                n_cmp++; if (waited !== 2) begin n_err++; $display("FAIL b2b_gap got=%0d want=2", waited); end
            end
        end
        wait_idle(tmo);
        n_cmp++; if (rde_pulses - r0 !== 2) begin n_err++; $display("FAIL b2b_rde_count got=%0d want=2", rde_pulses - r0); end
    endtask

    task automatic test_frame_len;
        logic [10:0] bits; logic stable; int waited; logic tmo; int sc;
        int b0; logic [7:0] e;
        b0 = busy_cycles;
        push_byte(8'h07);
        rx_frame(bits, stable, waited, tmo, sc);
        e = exp_q.pop_front();
        n_cmp++; if (bits !== make_frame(e)) begin n_err++; $display("FAIL len_frame got=%h want=%h", bits, make_frame(e)); end
`ifdef FIFO_UART_TX_PARITY_EN
        n_cmp++; if (bits[9] !== 1'b1) begin n_err++; $display("FAIL parity_bit got=%b want=1", bits[9]); end
`endif
        wait_idle(tmo);
        n_cmp++; if (busy_cycles - b0 !== int'(BUSY_EXP)) begin n_err++; $display("FAIL len_busy got=%0d want=%0d", busy_cycles - b0, BUSY_EXP); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits; logic stable; int waited; logic tmo; int sc;
        int r0, p0, t0, b0; logic [7:0] e;
        push_byte(8'hF0);
        bits = '1; waited = 0; tmo = 1'b0;
        forever begin
            @(negedge clk_w);
            if (tx === 1'b0) break;
            waited++;
            if (waited > 300) begin tmo = 1'b1; break; end
        end
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL mid_start_timeout got=%b want=0", tmo); end
        repeat (4 * CLKS + 1) @(negedge clk_w);
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL mid_data3_tx got=%b want=0", tx); end
        e = exp_q.pop_front();
        reset = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL mid_async_tx got=%b want=1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_async_busy got=%b want=0", busy); end
        repeat (2) @(negedge clk_w);
        r0 = rde_pulses; p0 = rd_ptr; t0 = tx_low_cycles; b0 = busy_cycles;
        reset = 1'b1;
        repeat (20) @(negedge clk_w);
        n_cmp++; if (rde_pulses - r0 !== 0) begin n_err++; $display("FAIL mid_no_repop got=%0d want=0", rde_pulses - r0); end
        n_cmp++; if (rd_ptr !== p0) begin n_err++; $display("FAIL mid_rd_ptr got=%0d want=%0d", rd_ptr, p0); end
        n_cmp++; if (tx_low_cycles - t0 !== 0) begin n_err++; $display("FAIL mid_tx_idle got=%0d want=0", tx_low_cycles - t0); end
        n_cmp++; if (busy_cycles - b0 !== 0) begin n_err++; $display("FAIL mid_busy_idle got=%0d want=0", busy_cycles - b0); end
    endtask

    task automatic test_idle;
        int r0, t0;
        r0 = rde_pulses; t0 = tx_low_cycles;
        repeat (100) @(negedge clk_w);
        n_cmp++; if (rde_pulses - r0 !== 0) begin n_err++; $display("FAIL idle_rde got=%0d want=0", rde_pulses - r0); end
        n_cmp++; if (tx_low_cycles - t0 !== 0) begin n_err++; $display("FAIL idle_tx got=%0d want=0", tx_low_cycles - t0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_len();
        test_reset_mid();
        test_idle();
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4, meaning clk_w cycles per serial bit (legal range 2..255).
REQ-002 The module SHALL have port clk_w  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-005 The module SHALL have port fifo_rde  output  1  one-cycle read-enable pulse to the FIFO.
REQ-006 The module SHALL have port fifo_rdd  input  8  FIFO read data, valid the cycle after fifo_rde.
REQ-007 The module SHALL have port tx  output  1  serial line, idle high.
REQ-008 The module SHALL have port busy  output  1  high from POP entry until STOP completes.

Function
REQ-009 The state machine SHALL have states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-010 In IDLE with fifo_empty=0, the machine SHALL enter POP on the next edge; in IDLE with fifo_empty=1, it SHALL remain in IDLE.
REQ-011 POP SHALL last one cycle with fifo_rde=1; fifo_rde SHALL be 0 in every other state.
REQ-012 LOAD SHALL last one cycle and capture fifo_rdd into an 8-bit shift register.
REQ-013 START, each DATA bit, PARITY and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles, timed by a bit counter that restarts at every bit boundary.
REQ-014 tx SHALL be 0 in START, shift-register bit 0 in DATA (LSB first, 8 bits, 3-bit index wrapping 7->0 on exit), and 1 in STOP, IDLE, POP and LOAD.
REQ-015 At the end of STOP, the machine SHALL go to POP if fifo_empty=0 (back-to-back frames, no idle bit), and to IDLE otherwise.
REQ-016 fifo_empty SHALL be sampled only in IDLE and at the end of STOP; changes during a frame SHALL be ignored.
REQ-017 The first-bit latency SHALL be tx falling 2 cycles after the edge that leaves IDLE (POP, then LOAD, then START).
REQ-018 busy SHALL be 0 only in IDLE.

Reset
REQ-019 While reset=0, the module SHALL hold state=IDLE, tx=1, fifo_rde=0, busy=0, with counters and shift register at 0, regardless of clk_w.
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; the byte SHALL be lost and not re-popped.
REQ-021 After reset release, the first FIFO pop SHALL occur no earlier than the first clk_w edge.

Configuration
REQ-022 With macro FIFO_UART_TX_PARITY_EN defined, the PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-023 Without FIFO_UART_TX_PARITY_EN, PARITY SHALL be unreachable, DATA SHALL go directly to STOP, and the frame SHALL be 10 bits.

Structure
REQ-024 Package fifo_uart_pkg SHALL hold the state encoding constants, DATA_W=8 and the frame-length constants for both macro settings.
REQ-025 Sub-module baud_tick SHALL hold the CLKS_PER_BIT counter, with a restart input and a one-cycle bit_done output.

Verification
REQ-026 Scenario: CLKS_PER_BIT=4, FIFO holds 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; one fifo_rde pulse; busy high for 42 cycles.
REQ-027 Scenario: FIFO holds 0xA5 and 0xAA back-to-back -> the second START immediately follows the first STOP; exactly 2 fifo_rde pulses.
REQ-028 Scenario: FIFO_UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after bit 7; 11-bit frame of 44 cycles.
REQ-029 Scenario: reset=0 during DATA bit 3 -> tx=1 and busy=0 without waiting for a clock edge; FIFO pointer unchanged after release while fifo_empty=1.
REQ-030 Scenario: fifo_empty=1 for 100 cycles -> fifo_rde never asserted; tx constantly 1.
